svreal_seq_div: RTL and testbench



---
 rtl/svreal_div_pkg.sv | 38 +++
 rtl/svreal_div_core.sv | 76 +++++++
 rtl/svreal_seq_div.sv | 154 +++++++++++++++
 tb/tb_svreal_seq_div.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/svreal_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : svreal_div_pkg
// Purpose  : Shared types and elaboration helpers for the svreal sequential
//            fixed-point divider (state encoding, derived widths, limits).
// Revision : 1.0 - initial release
// ============================================================================
package svreal_div_pkg;

    // Handshake FSM states of the divider top level
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Left shift applied to the dividend so the quotient lands on EXP_Q
    function automatic int calc_shift(input int exp_a, input int exp_b, input int exp_q);
        return exp_a - exp_b - exp_q;
    endfunction

    // Width of the shifted dividend magnitude fed to the iteration
    function automatic int calc_num_w(input int width_a, input int shift);
        return width_a + shift;
    endfunction

    // Largest positive value of a w-bit two's complement number
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value of a w-bit two's complement number
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/svreal_div_core.sv
`default_nettype none
// ============================================================================
// Module   : svreal_div_core
// Purpose  : Unsigned restoring division, one quotient bit per clock.
//            A start pulse loads numerator/denominator; done pulses for one
//            cycle after the last of NUM_W iterations.
// Revision : 1.0 - initial release
// ============================================================================
module svreal_div_core #(
    parameter int NUM_W   = 27,
    parameter int WIDTH_B = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_W-1:0]   num,
    input  logic [WIDTH_B-1:0] den,
    output logic [NUM_W-1:0]   quo,
    output logic               done
);

    localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_W - 1);

    logic [NUM_W-1:0]   r_num;
    logic [WIDTH_B-1:0] r_den;
    logic [WIDTH_B-1:0] r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    logic [WIDTH_B:0]   w_trial;
    logic               w_ge;
    logic [WIDTH_B-1:0] w_diff;

    // Trial remainder: shift in the next numerator bit, MSB first. The
    // remainder is always below den, so the difference fits in WIDTH_B bits.
    always_comb begin
        w_trial = {r_rem, r_num[NUM_W-1]};
        w_ge    = (w_trial >= {1'b0, r_den});
        w_diff  = w_trial[WIDTH_B-1:0] - r_den;
    end

    // Iteration registers: load on start, then one restoring step per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num  <= '0;
            r_den  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            quo    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_num  <= num;
                r_den  <= den;
                r_rem  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
                quo    <= '0;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff : w_trial[WIDTH_B-1:0];
                quo   <= NUM_W'({quo, w_ge});
                r_num <= r_num << 1;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == C_LAST) begin
                    r_busy <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/svreal_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : svreal_seq_div
// Purpose  : Sequential svreal fixed-point divider q = a / b with valid/ready
//            handshakes, sign handling, saturation and divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module svreal_seq_div
    import svreal_div_pkg::*;
#(
    parameter int WIDTH_A = 16,
    parameter int EXP_A   = -8,
    parameter int WIDTH_B = 17,
    parameter int EXP_B   = -9,
    parameter int WIDTH_Q = 18,
    parameter int EXP_Q   = -10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH_A-1:0] a_sig,
    input  logic signed [WIDTH_B-1:0] b_sig,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH_Q-1:0] q_sig,
    output logic                      ovf,
    output logic                      div_zero
);

    localparam int SHIFT = calc_shift(EXP_A, EXP_B, EXP_Q);
    localparam int NUM_W = calc_num_w(WIDTH_A, SHIFT);
    localparam int CW    = ((NUM_W > WIDTH_Q) ? NUM_W : WIDTH_Q) + 1;

    localparam logic signed [WIDTH_Q-1:0] Q_MAX = WIDTH_Q'(sat_max(WIDTH_Q));
    localparam logic signed [WIDTH_Q-1:0] Q_MIN = WIDTH_Q'(sat_min(WIDTH_Q));
    localparam logic [CW-1:0] NEG_LIM = CW'(1) << (WIDTH_Q - 1);
    localparam logic [CW-1:0] POS_LIM = NEG_LIM - CW'(1);

    if (SHIFT < 0) begin : g_bad_shift
        $error("svreal_seq_div: EXP_A - EXP_B - EXP_Q must not be negative");
    end

    state_t r_state;
    state_t w_next;

    logic               r_sign;
    logic               r_a_neg;
    logic               r_b_zero;

    logic               w_accept;
    logic               w_b_is_zero;
    logic [WIDTH_A-1:0] w_a_abs;
    logic [WIDTH_B-1:0] w_b_abs;
    logic [NUM_W-1:0]   w_num;
    logic [NUM_W-1:0]   w_quo;
    logic               w_core_done;

    logic [CW-1:0]        w_mag;
    logic [WIDTH_Q-1:0]   w_mag_lo;
    logic                 w_ovf;
    logic signed [WIDTH_Q-1:0] w_q_res;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid & in_ready;

    // Operand magnitudes; the most negative input maps to 2^(W-1) unsigned
    always_comb begin
        w_b_is_zero = (b_sig == '0);
        w_a_abs     = a_sig[WIDTH_A-1] ? (~a_sig + WIDTH_A'(1)) : a_sig;
        w_b_abs     = b_sig[WIDTH_B-1] ? (~b_sig + WIDTH_B'(1)) : b_sig;
        w_num       = NUM_W'(w_a_abs) << SHIFT;
    end

    svreal_div_core #(
        .NUM_W   (NUM_W),
        .WIDTH_B (WIDTH_B)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept & ~w_b_is_zero),
        .num   (w_num),
        .den   (w_b_abs),
        .quo   (w_quo),
        .done  (w_core_done)
    );

    // Apply sign and clamp the magnitude quotient to the WIDTH_Q range
    always_comb begin
        w_mag    = CW'(w_quo);
        w_mag_lo = w_mag[WIDTH_Q-1:0];
        w_ovf    = r_sign ? (w_mag > NEG_LIM) : (w_mag > POS_LIM);
        if (w_ovf) begin
            w_q_res = r_sign ? Q_MIN : Q_MAX;
        end else begin
            w_q_res = r_sign ? -w_mag_lo : w_mag_lo;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a zero divisor spends one cycle in CALC then finishes
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = CALC;
            CALC:    if (r_b_zero || w_core_done) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand attributes captured at the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign   <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_accept) begin
            r_sign   <= a_sig[WIDTH_A-1] ^ b_sig[WIDTH_B-1];
            r_a_neg  <= a_sig[WIDTH_A-1];
            r_b_zero <= w_b_is_zero;
        end
    end

    // Result registers, loaded on the transition into DONE and held there
    always_ff @(posedge clk) begin
        if (rst) begin
            q_sig    <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else if (r_state == CALC) begin
            if (r_b_zero) begin
                q_sig    <= r_a_neg ? Q_MIN : Q_MAX;
                ovf      <= 1'b0;
                div_zero <= 1'b1;
            end else if (w_core_done) begin
                q_sig    <= w_q_res;
                ovf      <= w_ovf;
                div_zero <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_svreal_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_svreal_seq_div
// Purpose  : Self-checking bench for svreal_seq_div: directed and random
//            operands compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svreal_seq_div;

    localparam int     SHIFT  = 11;
    localparam longint Q_MAX  = 131071;
    localparam longint Q_MIN  = -131072;
    localparam int     LAT    = 28;
    localparam int     BOUND  = 200;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a_sig;
    logic signed [16:0] b_sig;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] q_sig;
    logic               ovf;
    logic               div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    svreal_seq_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sig     (a_sig),
        .b_sig     (b_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_sig     (q_sig),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: real-valued quotient scaled to EXP_Q, truncated, then clamped
    function automatic void model(input longint a, input longint b,
                                  output longint q, output longint ov, output longint dz);
        longint raw;
        if (b == 0) begin
            dz = 1; ov = 0;
            q  = (a >= 0) ? Q_MAX : Q_MIN;
        end else begin
            dz  = 0;
            raw = (a * (longint'(1) << SHIFT)) / b;
            if (raw > Q_MAX) begin
                q = Q_MAX; ov = 1;
            end else if (raw < Q_MIN) begin
                q = Q_MIN; ov = 1;
            end else begin
                q = raw; ov = 0;
            end
        end
    endfunction

    // One full transaction with optional consumer back-pressure
    task automatic run_op(input string tag, input logic signed [15:0] a,
                          input logic signed [16:0] b, input int hold);
        longint eq, eov, edz;
        int lat;
        model(a, b, eq, eov, edz);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        a_sig    = a;
        b_sig    = b;
        tick();
        in_valid = 1'b0;
        a_sig    = 16'($urandom);
        b_sig    = 17'($urandom);
        lat = 0;
        while (!out_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, (b == 0) ? 1 : LAT);
        check({tag, ".q"}, q_sig, eq);
        check({tag, ".ovf"}, ovf, eov);
        check({tag, ".div_zero"}, div_zero, edz);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_sig    = 16'($urandom);
            b_sig    = 17'($urandom);
            tick();
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_in_ready"}, in_ready, 0);
            check({tag, ".hold_q"}, q_sig, eq);
            check({tag, ".hold_flags"}, {ovf, div_zero}, {eov[0], edz[0]});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, out_valid, 0);
        check({tag, ".in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic signed [15:0] ra;
        logic signed [16:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_sig     = '0;
        b_sig     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.q", q_sig, 0);
        check("reset.ovf", ovf, 0);
        check("reset.div_zero", div_zero, 0);

        run_op("pos", 16'sd256, 17'sd256, 0);
        run_op("neg", -16'sd768, 17'sd1024, 0);
        run_op("third", 16'sd1, 17'sd3, 0);
        run_op("neg_third", -16'sd1, 17'sd3, 0);
        run_op("ovf_pos", 16'sd32767, 17'sd1, 0);
        run_op("ovf_neg", -16'sd32768, 17'sd1, 0);
        run_op("dz_pos", 16'sd256, 17'sd0, 0);
        run_op("dz_neg", -16'sd256, 17'sd0, 0);
        run_op("neg_div", 16'sd1000, -17'sd65536, 0);
        run_op("backpressure", 16'sd300, -17'sd7, 10);

        // Abort an operation part-way through CALC
        in_valid = 1'b1;
        a_sig    = 16'sd256;
        b_sig    = 17'sd256;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.in_ready", in_ready, 1);
        check("abort.out_valid", out_valid, 0);
        check("abort.q", q_sig, 0);
        check("abort.ovf", ovf, 0);
        check("abort.div_zero", div_zero, 0);
        run_op("after_abort", 16'sd256, 17'sd256, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 17'($urandom);
            if (i % 4 == 1) rb = 17'($urandom_range(0, 6)) - 17'sd3;
            if (i % 4 == 2) rb = 17'($urandom_range(1, 255));
            run_op("random", ra, rb, i % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
